shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have the parameter BASE_DIV, default 4, which sets the shift period in CTL_CLK cycles for spd_sel=00.
REQ-002 The block SHALL have the parameter CNT_W, default 4, which sets the width of shift_cnt and of the internal shift counter.
REQ-003 The block SHALL have port CTL_CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port CTL_RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port spd_sel, input, 2 bits: shift-rate select, sampled at run start.
REQ-006 The block SHALL have port start, input, 1 bit: run request, level-sampled in IDLE.
REQ-007 The block SHALL have port stop, input, 1 bit: run abort.
REQ-008 The block SHALL have port shift_cnt, input, CNT_W bits: shifts per run, sampled at run start; 0 means continuous.
REQ-009 The block SHALL have port load_req, input, 1 bit: parallel-load request.
REQ-010 The block SHALL have port load_data, input, 8 bits: pattern to load, captured with load_req.
REQ-011 The block SHALL have port load_ack, output, 1 bit: one-cycle pulse confirming a load was issued.
REQ-012 The block SHALL have port sh_ld, output, 1 bit: active-low load strobe to the shift register.
REQ-013 The block SHALL have port sr_data, output, 8 bits: load pattern presented to the shift register.
REQ-014 The block SHALL have port sr_en, output, 1 bit: one-cycle shift enable.
REQ-015 The block SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse marking completion of a counted run.

Function
REQ-017 The state machine SHALL have exactly four states: IDLE, LOAD, RUN and DONE, and SHALL never leave IDLE except on load_req or start.
REQ-018 In IDLE, when load_req=1, the block SHALL capture load_data into sr_data and enter LOAD on the next edge.
REQ-019 LOAD SHALL last exactly one cycle, drive sh_ld=0 and load_ack=1 for that cycle, then return to IDLE.
REQ-020 In IDLE with load_req=1 and start=1 in the same cycle, load SHALL win; start is re-evaluated once back in IDLE.
REQ-021 In IDLE with start=1 and load_req=0, the block SHALL latch spd_sel and shift_cnt, clear the divider and shift counter, and enter RUN.
REQ-022 The shift period SHALL be P = BASE_DIV << (2*spd_sel) cycles (default 4/16/64/256); the divider SHALL count 0..P-1 and wrap to 0.
REQ-023 In RUN, sr_en SHALL pulse for one cycle when the divider is at P-1; the first pulse SHALL occur P cycles after RUN entry.
REQ-024 Each sr_en pulse SHALL increment the shift counter; the counter wraps modulo 2^CNT_W when shift_cnt=0.
REQ-025 With latched shift_cnt=N>0, the edge issuing the Nth sr_en SHALL move to DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-026 With latched shift_cnt=0, RUN SHALL continue indefinitely until stop.
REQ-027 stop=1 in RUN SHALL return to IDLE on the next edge with no done pulse; if stop coincides with a divider terminal count, sr_en SHALL stay 0 that cycle.
REQ-028 stop SHALL be ignored outside RUN.
REQ-029 load_req during RUN or DONE SHALL not be serviced; if it is still held when the block reaches IDLE, it SHALL be serviced then.
REQ-030 spd_sel and shift_cnt changes during RUN SHALL have no effect until the next start.
REQ-031 sh_ld SHALL be 0 only in LOAD, and sh_ld=0 SHALL never coincide with sr_en=1.
REQ-032 busy SHALL be 1 exactly in RUN; load_ack, done and sr_en SHALL each be high for at most one cycle per event.

Reset
REQ-033 While CTL_RST_N=0, the block SHALL immediately force: state=IDLE, divider=0, shift counter=0, sh_ld=1, sr_en=0, load_ack=0, done=0, busy=0, sr_data=8'h01.
REQ-034 Reset asserted mid-RUN or mid-LOAD SHALL abort the operation with no done or load_ack pulse.
REQ-035 After CTL_RST_N deasserts, the first state change SHALL occur on the first CTL_CLK edge at which start or load_req is sampled.

Verification
REQ-036 The bench SHALL verify reset: drive CTL_RST_N=0 asynchronously mid-RUN and confirm all outputs take their REQ-033 values without waiting for a clock edge.
REQ-037 The bench SHALL verify load: load_req=1 with load_data=8'hA5 in IDLE, and confirm sr_data=8'hA5 with sh_ld=0 and load_ack=1 for exactly one cycle.
REQ-038 The bench SHALL verify a counted run: spd_sel=00, shift_cnt=3, start, and confirm sr_en pulses at cycles 4, 8 and 12 after RUN entry, done at cycle 13, then IDLE.
REQ-039 The bench SHALL verify rate select: spd_sel=10 with continuous mode, and confirm a 64-cycle sr_en spacing held across a mid-run spd_sel change.
REQ-040 The bench SHALL verify stop on terminal count: assert stop on the divider's P-1 cycle, and confirm no sr_en, no done, and IDLE next cycle.
REQ-041 The bench SHALL verify simultaneous requests: start and load_req together in IDLE, and confirm LOAD first, then RUN on the following IDLE cycle.

Source files
------------

// File: rtl/shift_sequencer.sv
// Shift-register sequencer: issues parallel loads and divided-rate shift enables
// for an external 8-bit shift register, with counted or continuous runs.
module shift_sequencer #(
    parameter int BASE_DIV = 4,
    parameter int CNT_W    = 4
) (
    input  logic             CTL_CLK,
    input  logic             CTL_RST_N,
    input  logic [1:0]       spd_sel,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] shift_cnt,
    input  logic             load_req,
    input  logic [7:0]       load_data,
    output logic             load_ack,
    output logic             sh_ld,
    output logic [7:0]       sr_data,
    output logic             sr_en,
    output logic             busy,
    output logic             done
);

    // Divider must hold the slowest period minus one (spd_sel = 11).
    localparam int DIV_W = $clog2(BASE_DIV * 64);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       spd_reg;
    logic [CNT_W-1:0] len_reg;
    logic [7:0]       sr_data_reg;

    logic [DIV_W-1:0] div_last;
    logic             div_tc;
    logic             last_shift;
    logic             run_start;

    always_comb begin
        int period;
        period   = BASE_DIV << (2 * int'(spd_reg));
        div_last = DIV_W'(period - 1);
    end

    assign div_tc     = (div_reg == div_last);
    assign last_shift = (len_reg != '0) && (CNT_W'(cnt_reg + 1'b1) == len_reg);
    assign run_start  = (state_reg == ST_IDLE) && !load_req && start;

    // A terminal count that coincides with stop is suppressed.
    assign sr_en    = (state_reg == ST_RUN) && div_tc && !stop;
    assign busy     = (state_reg == ST_RUN);
    assign done     = (state_reg == ST_DONE);
    assign load_ack = (state_reg == ST_LOAD);
    assign sh_ld    = (state_reg != ST_LOAD);
    assign sr_data  = sr_data_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_req) begin
                    state_next = ST_LOAD;
                end else if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_LOAD: state_next = ST_IDLE;
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (sr_en && last_shift) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CTL_CLK or negedge CTL_RST_N) begin
        if (!CTL_RST_N) begin
            state_reg   <= ST_IDLE;
            div_reg     <= '0;
            cnt_reg     <= '0;
            spd_reg     <= '0;
            len_reg     <= '0;
            sr_data_reg <= 8'h01;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && load_req) begin
                sr_data_reg <= load_data;
            end
            if (run_start) begin
                spd_reg <= spd_sel;
                len_reg <= shift_cnt;
                div_reg <= '0;
                cnt_reg <= '0;
            end else if (state_reg == ST_RUN) begin
                div_reg <= div_tc ? '0 : DIV_W'(div_reg + 1'b1);
                if (sr_en) begin
                    cnt_reg <= CNT_W'(cnt_reg + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized scenario bench for shift_sequencer; expected timing comes from the
// period/count arithmetic of each run rather than from a cycle-level model.
module tb_shift_sequencer;

    localparam int BASE_DIV = 4;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst_n;
    logic [1:0]       spd_sel;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] shift_cnt;
    logic             load_req;
    logic [7:0]       load_data;
    logic             load_ack;
    logic             sh_ld;
    logic [7:0]       sr_data;
    logic             sr_en;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    shift_sequencer #(.BASE_DIV(BASE_DIV), .CNT_W(CNT_W)) dut (
        .CTL_CLK   (clk),
        .CTL_RST_N (rst_n),
        .spd_sel   (spd_sel),
        .start     (start),
        .stop      (stop),
        .shift_cnt (shift_cnt),
        .load_req  (load_req),
        .load_data (load_data),
        .load_ack  (load_ack),
        .sh_ld     (sh_ld),
        .sr_data   (sr_data),
        .sr_en     (sr_en),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs packed as {busy, sr_en, done, load_ack, sh_ld}.
    function automatic logic [4:0] outs();
        return {busy, sr_en, done, load_ack, sh_ld};
    endfunction

    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b0; start = 0; stop = 0; load_req = 0;
        spd_sel = 0; shift_cnt = 0; load_data = 0;
        repeat (2) @(negedge clk);
        #1;
        got = outs();
        n_cmp++;
        if (got !== 5'b00001 || sr_data !== 8'h01) begin
            n_bad++;
            $display("FAIL reset_state: outs=%b sr_data=%h, want outs=00001 sr_data=01", got, sr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            spd_sel = 2'($urandom); shift_cnt = 4'($urandom); stop = 1'($urandom);
            #1;
            got = outs();
            n_cmp++;
            if (got !== 5'b00001 || sr_data !== 8'h01) begin
                n_bad++;
                $display("FAIL reset_idle_hold: cycle %0d outs=%b sr_data=%h, want 00001/01", k, got, sr_data);
            end
        end
        stop = 0;
        $display("reset: outputs idle, no state change without start/load_req");
    endtask

    task automatic test_load(input logic [7:0] d);
        logic [4:0] got;
        @(negedge clk);
        load_req = 1'b1; load_data = d;
        #1;
        got = outs();
        n_cmp++;
        if (got !== 5'b00001) begin
            n_bad++;
            $display("FAIL load_pre: outs=%b, want 00001", got);
        end
        @(negedge clk);
        load_req = 1'b0; load_data = 8'($urandom);
        #1;
        got = outs();
        n_cmp++;
        if (got !== 5'b00010 || sr_data !== d) begin
            n_bad++;
            $display("FAIL load_strobe: outs=%b sr_data=%h, want 00010 sr_data=%h", got, sr_data, d);
        end
        @(negedge clk);
        #1;
        got = outs();
        n_cmp++;
        if (got !== 5'b00001 || sr_data !== d) begin
            n_bad++;
            $display("FAIL load_post: outs=%b sr_data=%h, want 00001 sr_data=%h", got, sr_data, d);
        end
        $display("load: data=%h", d);
    endtask

    // Run of n shifts at rate spd: sr_en every P cycles, done one cycle after the last.
    task automatic test_counted_run(input logic [1:0] spd, input int n, input bit perturb);
        int p;
        int last;
        logic [4:0] got, want;
        p = BASE_DIV << (2 * int'(spd));
        last = n * p;
        @(negedge clk);
        spd_sel = spd; shift_cnt = CNT_W'(n); start = 1'b1;
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (perturb) begin
                spd_sel = 2'($urandom); shift_cnt = CNT_W'($urandom);
            end
            #1;
            got = outs();
            want = {k <= last, (k % p == 0) && (k <= last), k == last + 1, 1'b0, 1'b1};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL counted_run: spd=%0d n=%0d cycle %0d outs=%b, want %b", spd, n, k, got, want);
            end
        end
        $display("counted run: spd=%0d n=%0d period=%0d perturb=%0d", spd, n, p, perturb);
    endtask

    task automatic test_rate_select();
        logic [4:0] got, want;
        @(negedge clk);
        spd_sel = 2'b10; shift_cnt = 0; start = 1'b1;
        for (int k = 1; k <= 202; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 100) begin
                spd_sel = 2'b00; shift_cnt = 4'd1;
            end
            stop = (k == 201);
            #1;
            got = outs();
            if (k <= 201) want = {1'b1, (k % 64 == 0) && (k != 201), 1'b0, 1'b0, 1'b1};
            else          want = 5'b00001;
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL rate_select: cycle %0d outs=%b, want %b", k, got, want);
            end
        end
        stop = 1'b0;
        $display("rate select: spd=10 continuous, 64-cycle spacing, stopped at cycle 201");
    endtask

    task automatic test_stop_tc();
        logic [4:0] got, want;
        @(negedge clk);
        spd_sel = 2'b00; shift_cnt = 4'd3; start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop = (k == 12);
            #1;
            got = outs();
            if (k <= 11)       want = {1'b1, k % 4 == 0, 1'b0, 1'b0, 1'b1};
            else if (k == 12)  want = 5'b10001;
            else               want = 5'b00001;
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL stop_tc: cycle %0d outs=%b, want %b", k, got, want);
            end
        end
        stop = 1'b0;
        $display("stop on terminal count: suppressed final shift and done");
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        logic [4:0] got, want;
        d = 8'($urandom);
        @(negedge clk);
        start = 1'b1; load_req = 1'b1; load_data = d; spd_sel = 2'b00; shift_cnt = 4'd1;
        // cycle 1 LOAD, 2 IDLE, 3..6 RUN (shift at 6), 7 DONE, 8 IDLE
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            load_req = 1'b0;
            if (k == 3) start = 1'b0;
            #1;
            got = outs();
            want = {(k >= 3) && (k <= 6), k == 6, k == 7, k == 1, k != 1};
            n_cmp++;
            if (got !== want || sr_data !== d) begin
                n_bad++;
                $display("FAIL simultaneous: cycle %0d outs=%b sr_data=%h, want %b/%h", k, got, sr_data, want, d);
            end
        end
        $display("simultaneous start+load: load first, then run, data=%h", d);
    endtask

    task automatic test_held_load();
        logic [7:0] d, old;
        logic [4:0] got, want;
        d = 8'($urandom);
        old = sr_data;
        @(negedge clk);
        spd_sel = 2'b00; shift_cnt = 4'd1; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin
                load_req = 1'b1; load_data = d;
            end
            if (k == 7) load_req = 1'b0;
            #1;
            got = outs();
            want = {k <= 4, k == 4, k == 5, k == 7, k != 7};
            n_cmp++;
            if (got !== want || sr_data !== ((k >= 7) ? d : old)) begin
                n_bad++;
                $display("FAIL held_load: cycle %0d outs=%b sr_data=%h, want %b/%h", k, got, sr_data,
                         want, (k >= 7) ? d : old);
            end
        end
        $display("load held through run: serviced after return to idle, data=%h", d);
    endtask

    task automatic test_async_reset();
        logic [4:0] got;
        @(negedge clk);
        spd_sel = 2'b00; shift_cnt = 4'd0; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        got = outs();
        n_cmp++;
        if (got !== 5'b11001) begin
            n_bad++;
            $display("FAIL async_pre: outs=%b, want 11001", got);
        end
        rst_n = 1'b0;
        #1;
        got = outs();
        n_cmp++;
        if (got !== 5'b00001 || sr_data !== 8'h01) begin
            n_bad++;
            $display("FAIL async_reset: outs=%b sr_data=%h, want 00001/01", got, sr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            got = outs();
            n_cmp++;
            if (got !== 5'b00001) begin
                n_bad++;
                $display("FAIL async_post: cycle %0d outs=%b, want 00001", k, got);
            end
        end
        $display("async reset mid-run: outputs forced without a clock edge");
    endtask

    initial begin
        test_reset();
        test_load(8'hA5);
        for (int i = 0; i < 3; i++) test_load(8'($urandom));
        test_counted_run(2'b00, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            test_counted_run(2'($urandom_range(0, 1)), int'($urandom_range(1, 5)), 1'b1);
        end
        test_rate_select();
        test_stop_tc();
        test_simultaneous();
        test_held_load();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
